// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter (shift-and-add-3).
// Takes a WIDTH-bit binary value on an init_in pulse and, 2*WIDTH cycles
// later, presents DIGITS packed BCD digits on bcd_out with done high.
// One ADJ step plus one SHIFT step is spent per input bit.
// Optional build macro: BIN2BCD_LZB_EN enables leading-zero blanking
// (digits above the most-significant nonzero digit become 4'hF).
module bin2bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init_in,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_START = 2'd0;
  localparam logic [1:0] S_ADJ   = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_END1  = 2'd3;

  logic [1:0]            r_state;
  logic [4*DIGITS-1:0]   r_bcd_work;
  logic [WIDTH-1:0]      r_bin_work;
  logic [CW-1:0]         r_cnt;
  logic [4*DIGITS-1:0]   r_bcd_out;

  logic [4*DIGITS-1:0]   w_adj_bcd;
  logic [4*DIGITS-1:0]   w_shift_bcd;
  logic [WIDTH-1:0]      w_shift_bin;
  logic [CW-1:0]         w_cnt_dec;
  logic [4*DIGITS-1:0]   w_bcd_final;
`ifdef BIN2BCD_LZB_EN
  logic                  w_lead;
`endif

  // Add-3 correction: each digit >= 5 gets +3, wrapping inside its nibble.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and assign a default
    // first, so every path drives the output and no latch is inferred.
    w_adj_bcd = r_bcd_work;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_bcd_work[4*i +: 4] >= 4'd5)
        w_adj_bcd[4*i +: 4] = r_bcd_work[4*i +: 4] + 4'd3;
    end
  end

  // One-bit left shift of {bcd_work, bin_work} and the decremented counter.
  assign w_shift_bcd = {r_bcd_work[4*DIGITS-2:0], r_bin_work[WIDTH-1]};
  assign w_shift_bin = {r_bin_work[WIDTH-2:0], 1'b0};
  assign w_cnt_dec   = r_cnt - CW'(1);

  // Value copied into bcd_out on the final shift (optionally blanked).
  always_comb begin
    w_bcd_final = w_shift_bcd;
`ifdef BIN2BCD_LZB_EN
    // Walk down from the top digit, blanking zeros until the first nonzero
    // digit; digit 0 is never blanked so a zero result still shows "0".
    w_lead = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (w_lead && (w_shift_bcd[4*i +: 4] == 4'd0))
        w_bcd_final[4*i +: 4] = 4'hF;
      else
        w_lead = 1'b0;
    end
`endif
  end

  // ASM controller and datapath registers; bcd_out only updates on completion.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking '<=' so every register
    // samples pre-edge values, independent of statement order.
    if (!rst) begin
      r_state    <= S_START;
      r_bcd_work <= '0;
      r_bin_work <= '0;
      r_cnt      <= '0;
      r_bcd_out  <= '0;
    end else begin
      case (r_state)
        S_START, S_END1: begin
          if (init_in) begin
            r_bin_work <= bin_in;
            r_bcd_work <= '0;
            r_cnt      <= CW'(WIDTH);
            r_state    <= S_ADJ;
          end
        end
        S_ADJ: begin
          r_bcd_work <= w_adj_bcd;
          r_state    <= S_SHIFT;
        end
        S_SHIFT: begin
          r_bcd_work <= w_shift_bcd;
          r_bin_work <= w_shift_bin;
          r_cnt      <= w_cnt_dec;
          if (w_cnt_dec == '0) begin
            r_bcd_out <= w_bcd_final;
            r_state   <= S_END1;
          end else begin
            r_state   <= S_ADJ;
          end
        end
        default: r_state <= S_START;
      endcase
    end
  end

  // Moore outputs decoded from the state register.
  assign busy    = (r_state == S_ADJ) || (r_state == S_SHIFT);
  assign done    = (r_state == S_END1);
  assign bcd_out = r_bcd_out;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: scoreboard bench for bin2bcd_seq. Stimulus pushes the
// decimal-arithmetic expectation and its due cycle into a queue; a monitor
// pops and compares on every rising edge of done and watches bcd_out
// stability and busy length in between.
module tb_bin2bcd_seq;

  localparam int W = 16;
  localparam int D = 5;

  typedef struct {
    logic [4*D-1:0] bcd;
    int             due;
  } exp_t;

  logic           clk;
  logic           rst;
  logic           init_in;
  logic [W-1:0]   bin_in;
  logic           busy;
  logic           done;
  logic [4*D-1:0] bcd_out;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   cyc    = 0;

  bin2bcd_seq #(.WIDTH(W), .DIGITS(D)) dut (
    .clk     (clk),
    .rst     (rst),
    .init_in (init_in),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // Reference: decimal digits by repeated division, then optional blanking.
  function automatic logic [4*D-1:0] ref_bcd(input int unsigned v);
    logic [4*D-1:0] r;
    int unsigned    x;
    int             msd;
    r   = '0;
    x   = v;
    msd = 0;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      if (x % 10 != 0) msd = i;
      x = x / 10;
    end
`ifdef BIN2BCD_LZB_EN
    for (int i = 1; i < D; i++)
      if (i > msd) r[4*i +: 4] = 4'hF;
`endif
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: compares on done rise, checks bcd_out holds otherwise.
  initial begin : monitor
    logic           prev_done;
    logic [4*D-1:0] last;
    int             busy_cnt;
    exp_t           e;
    prev_done = 1'b0;
    last      = '0;
    busy_cnt  = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_done = 1'b0;
        last      = '0;
        busy_cnt  = 0;
      end else begin
        if (busy) busy_cnt++;
        if (done && !prev_done) begin
          if (exp_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("bcd_result", 32'(bcd_out), 32'(e.bcd));
            check("done_latency", 32'(cyc), 32'(e.due));
            check("busy_cycles", 32'(busy_cnt), 32'(2*W));
            last = e.bcd;
          end
          busy_cnt = 0;
        end else begin
          check("bcd_hold", 32'(bcd_out), 32'(last));
        end
        if (busy && done) check("busy_done_excl", 32'd1, 32'd0);
        prev_done = done;
      end
    end
  end

  // Drive one init pulse; sampling edge is the next posedge.
  task automatic issue(input logic [W-1:0] v, input bit push);
    exp_t e;
    @(posedge clk); #1;
    init_in = 1'b1;
    bin_in  = v;
    if (push) begin
      e.bcd = ref_bcd(int'(v));
      e.due = cyc + 1 + 2*W;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    init_in = 1'b0;
    bin_in  = W'($urandom);
  endtask

  // Bounded wait for done; expiry counts as a failed comparison.
  task automatic wait_done();
    int k;
    k = 0;
    while (!done && k < 4*W) begin
      @(negedge clk);
      k++;
    end
    if (!done) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [W-1:0] v;
    rst     = 1'b0;
    init_in = 1'b0;
    bin_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bcd",  32'(bcd_out), 32'd0);
    rst = 1'b1;

    // Basic value, then boundary values.
    issue(16'd1234, 1'b1); wait_done();
    issue(16'hFFFF, 1'b1); wait_done();
    issue(16'd0,    1'b1); wait_done();

    // init_in during busy is ignored; bin_in wiggles meanwhile.
    issue(16'd1234, 1'b1);
    repeat (5) @(posedge clk);
    issue(16'd9999, 1'b0);
    wait_done();

    // Restart from END1: done drops right after the sampling edge.
    repeat (3) @(posedge clk);
    issue(16'd42, 1'b1);
    @(negedge clk);
    check("end1_done_drop", 32'(done), 32'd0);
    wait_done();

    // Back-to-back random conversions.
    for (int i = 0; i < 24; i++) begin
      v = W'($urandom);
      issue(v, 1'b1);
      @(negedge clk);
      wait_done();
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 4)) @(posedge clk);
    end

    // Asynchronous reset mid-conversion, away from any clock edge.
    issue(16'd777, 1'b1);
    repeat (9) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("async_busy", 32'(busy), 32'd0);
    check("async_done", 32'(done), 32'd0);
    check("async_bcd",  32'(bcd_out), 32'd0);
    exp_q.delete();
    @(posedge clk); #2;
    check("held_bcd", 32'(bcd_out), 32'd0);
    rst = 1'b1;

    issue(16'd500, 1'b1); wait_done();

    repeat (4) @(posedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
